// File: rtl/mc_controller.sv
// Multi-cycle MIPS controller: decodes IR and sequences FETCH/DECODE/EXEC/MEM/WB/MDU.
// Optional MC_ILLEGAL_TRAP_EN: illegal instructions halt the FSM and raise 'illegal'.
module mc_controller #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        cmp_true,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        ir_we,
   output logic        reg_we,
   output logic [1:0]  rd_sel,
   output logic [1:0]  d2r,
   output logic [4:0]  alu_op,
   output logic        alu_srcA,
   output logic        alu_srcB,
   output logic        imm_ext,
   output logic        mem_we,
   output logic [1:0]  width_op,
   output logic        sign_or_zero,
   output logic        md_start,
   output logic [1:0]  md_op,
   output logic        md_busy,
   output logic        instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic        illegal,
`endif
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_MDU    = 3'd5
`ifdef MC_ILLEGAL_TRAP_EN
      , S_HALT = 3'd6
`endif
   } state_t;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_OR  = 5'd2;
   localparam logic [4:0] ALU_LUI = 5'd3;
   localparam logic [4:0] ALU_SLL = 5'd4;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [5:0] op, fn;
   logic       c_r, c_jr, c_md, c_mf, c_ld, c_st, c_br, c_j, c_jal, c_ill;
   logic [4:0] dec_alu_op;
   logic       dec_src_a, dec_src_b, dec_zext, dec_sz;
   logic [1:0] dec_width;
   logic       unused_bits;

   assign op          = instr[31:26];
   assign fn          = instr[5:0];
   assign unused_bits = ^instr[25:6];

   always_comb begin
      c_r = 1'b0; c_jr = 1'b0; c_md = 1'b0; c_mf = 1'b0; c_ld = 1'b0;
      c_st = 1'b0; c_br = 1'b0; c_j = 1'b0; c_jal = 1'b0; c_ill = 1'b0;
      dec_alu_op = ALU_ADD; dec_src_a = 1'b0; dec_src_b = 1'b0;
      dec_zext = 1'b0; dec_sz = 1'b0; dec_width = 2'd0;
      case (op)
         6'h00: case (fn)
            6'h21: c_r = 1'b1;
            6'h23: begin c_r = 1'b1; dec_alu_op = ALU_SUB; end
            6'h00: begin c_r = 1'b1; dec_alu_op = ALU_SLL; dec_src_a = 1'b1; end
            6'h08: c_jr = 1'b1;
            6'h18, 6'h19, 6'h1A, 6'h1B: c_md = 1'b1;
            6'h10, 6'h12: begin c_r = 1'b1; c_mf = 1'b1; end
            default: c_ill = 1'b1;
         endcase
         6'h0D: begin dec_alu_op = ALU_OR; dec_src_b = 1'b1; dec_zext = 1'b1; end
         6'h0F: begin dec_alu_op = ALU_LUI; dec_src_b = 1'b1; end
         6'h23: begin c_ld = 1'b1; dec_src_b = 1'b1; end
         6'h21: begin c_ld = 1'b1; dec_src_b = 1'b1; dec_width = 2'd1; end
         6'h25: begin c_ld = 1'b1; dec_src_b = 1'b1; dec_width = 2'd1; dec_sz = 1'b1; end
         6'h20: begin c_ld = 1'b1; dec_src_b = 1'b1; dec_width = 2'd2; end
         6'h24: begin c_ld = 1'b1; dec_src_b = 1'b1; dec_width = 2'd2; dec_sz = 1'b1; end
         6'h2B: begin c_st = 1'b1; dec_src_b = 1'b1; end
         6'h29: begin c_st = 1'b1; dec_src_b = 1'b1; dec_width = 2'd1; end
         6'h28: begin c_st = 1'b1; dec_src_b = 1'b1; dec_width = 2'd2; end
         6'h04, 6'h05: c_br = 1'b1;
         6'h02: c_j = 1'b1;
         6'h03: c_jal = 1'b1;
         default: c_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_we = 1'b0; pc_sel = 2'd0; ir_we = 1'b0; reg_we = 1'b0;
      rd_sel = 2'd0; d2r = 2'd0; mem_we = 1'b0; md_start = 1'b0;
      md_busy = 1'b0; instr_done = 1'b0;
      alu_op = dec_alu_op; alu_srcA = dec_src_a; alu_srcB = dec_src_b;
      imm_ext = dec_zext; width_op = dec_width; sign_or_zero = dec_sz;
      md_op = fn[1:0];
      case (state_q)
         S_FETCH: begin
            ir_we = 1'b1; pc_we = 1'b1; state_d = S_DECODE;
         end
         S_DECODE: begin
            if (c_j || c_jal) begin
               pc_we = 1'b1; pc_sel = 2'd2; instr_done = 1'b1; state_d = S_FETCH;
               if (c_jal) begin reg_we = 1'b1; rd_sel = 2'd2; d2r = 2'd2; end
            end else if (c_ill) begin
`ifdef MC_ILLEGAL_TRAP_EN
               state_d = S_HALT;
`else
               instr_done = 1'b1; state_d = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (c_br) begin
               pc_we = cmp_true; pc_sel = 2'd1; instr_done = 1'b1; state_d = S_FETCH;
            end else if (c_jr) begin
               pc_we = 1'b1; pc_sel = 2'd3; instr_done = 1'b1; state_d = S_FETCH;
            end else if (c_md) begin
               // funct bit 1 separates div/divu from mult/multu
               md_start = 1'b1;
               cnt_d    = fn[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               state_d  = S_MDU;
            end else if (c_ld || c_st) begin
               alu_op = ALU_ADD; alu_srcB = 1'b1; state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (c_st) begin
               mem_we = 1'b1; instr_done = 1'b1; state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_we = 1'b1; instr_done = 1'b1; state_d = S_FETCH;
            rd_sel = c_r ? 2'd1 : 2'd0;
            d2r    = c_ld ? 2'd1 : (c_mf ? 2'd3 : 2'd0);
         end
         S_MDU: begin
            md_busy = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               instr_done = 1'b1; state_d = S_FETCH;
            end
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase
      // S_FETCH would otherwise assert ir_we/pc_we while reset is held low
      if (!reset) begin
         pc_we = 1'b0; pc_sel = 2'd0; ir_we = 1'b0; reg_we = 1'b0;
         rd_sel = 2'd0; d2r = 2'd0; mem_we = 1'b0; md_start = 1'b0;
         md_busy = 1'b0; instr_done = 1'b0; alu_op = '0; alu_srcA = 1'b0;
         alu_srcB = 1'b0; imm_ext = 1'b0; width_op = 2'd0;
         sign_or_zero = 1'b0; md_op = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle state, enable and select checks
// against hand-computed sequences for each instruction class.
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmp_true = 1'b0;
   logic [31:0] instr = 32'h0022_1821;
   logic        pc_we, ir_we, reg_we, alu_srcA, alu_srcB, imm_ext, mem_we;
   logic        sign_or_zero, md_start, md_busy, instr_done;
   logic [1:0]  pc_sel, rd_sel, d2r, width_op, md_op;
   logic [4:0]  alu_op;
   logic [2:0]  state;
`ifdef MC_ILLEGAL_TRAP_EN
   logic        illegal;
`endif
   logic [6:0]  en_v;
   logic [5:0]  sel_v;

   int unsigned n_err = 0;
   int unsigned n_chk = 0;

   always #5 clk = ~clk;

   mc_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .instr(instr), .cmp_true(cmp_true),
      .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .reg_we(reg_we),
      .rd_sel(rd_sel), .d2r(d2r), .alu_op(alu_op), .alu_srcA(alu_srcA),
      .alu_srcB(alu_srcB), .imm_ext(imm_ext), .mem_we(mem_we),
      .width_op(width_op), .sign_or_zero(sign_or_zero), .md_start(md_start),
      .md_op(md_op), .md_busy(md_busy), .instr_done(instr_done),
`ifdef MC_ILLEGAL_TRAP_EN
      .illegal(illegal),
`endif
      .state(state)
   );

   // {pc_we, ir_we, reg_we, mem_we, md_start, md_busy, instr_done}
   assign en_v  = {pc_we, ir_we, reg_we, mem_we, md_start, md_busy, instr_done};
   // {pc_sel, rd_sel, d2r}
   assign sel_v = {pc_sel, rd_sel, d2r};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // check the current cycle, then advance to just after the next rising edge
   task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] en,
                      input logic [5:0] mask, input logic [5:0] sel);
      check({tag, " state"}, 32'(state), 32'(st));
      check({tag, " en"}, 32'(en_v), 32'(en));
      if (mask != 6'd0) check({tag, " sel"}, 32'(sel_v & mask), 32'(sel & mask));
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string tag, input logic [31:0] i);
      instr = i;
      cyc({tag, " F"}, 3'd0, 7'b1100000, 6'b110000, 6'b000000);
   endtask

   initial begin
      #12;
      check("rst state", 32'(state), 32'd0);
      check("rst en", 32'(en_v), 32'd0);
      check("rst sel", 32'(sel_v), 32'd0);
      reset = 1'b1;
      #1;

      fetch("addu", 32'h0022_1821);
      cyc("addu D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      cyc("addu E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("addu W", 3'd4, 7'b0010001, 6'b001111, 6'b000100);

      fetch("lw", 32'h8C05_0004);
      cyc("lw D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("lw alu_op", 32'(alu_op), 32'd0);
      check("lw srcB", 32'(alu_srcB), 32'd1);
      cyc("lw E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("lw M", 3'd3, 7'b0000000, 6'b000000, 6'b000000);
      cyc("lw W", 3'd4, 7'b0010001, 6'b001111, 6'b000001);

      fetch("sw", 32'hAC05_0004);
      cyc("sw D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("sw width", 32'(width_op), 32'd0);
      cyc("sw E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("sw M", 3'd3, 7'b0001001, 6'b000000, 6'b000000);

      cmp_true = 1'b0;
      fetch("beq0", 32'h1022_0003);
      cyc("beq0 D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      cyc("beq0 E", 3'd2, 7'b0000001, 6'b110000, 6'b010000);
      cmp_true = 1'b1;
      fetch("beq1", 32'h1022_0003);
      cyc("beq1 D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      cyc("beq1 E", 3'd2, 7'b1000001, 6'b110000, 6'b010000);
      cmp_true = 1'b0;

      fetch("mult", 32'h0022_0018);
      cyc("mult D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("mult md_op", 32'(md_op), 32'd0);
      cyc("mult E", 3'd2, 7'b0000100, 6'b000000, 6'b000000);
      for (int i = 0; i < 4; i++) cyc("mult B", 3'd5, 7'b0000010, 6'b000000, 6'b000000);
      cyc("mult L", 3'd5, 7'b0000011, 6'b000000, 6'b000000);

      fetch("div", 32'h0022_001A);
      cyc("div D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("div md_op", 32'(md_op), 32'd2);
      cyc("div E", 3'd2, 7'b0000100, 6'b000000, 6'b000000);
      for (int i = 0; i < 9; i++) cyc("div B", 3'd5, 7'b0000010, 6'b000000, 6'b000000);
      cyc("div L", 3'd5, 7'b0000011, 6'b000000, 6'b000000);

      fetch("jal", 32'h0C00_0010);
      cyc("jal D", 3'd1, 7'b1010001, 6'b111111, 6'b101010);
      fetch("j", 32'h0800_0010);
      cyc("j D", 3'd1, 7'b1000001, 6'b110000, 6'b100000);

      fetch("jr", 32'h03E0_0008);
      cyc("jr D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      cyc("jr E", 3'd2, 7'b1000001, 6'b110000, 6'b110000);

      fetch("lbu", 32'h9005_0004);
      cyc("lbu D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("lbu soz", 32'(sign_or_zero), 32'd1);
      check("lbu width", 32'(width_op), 32'd2);
      cyc("lbu E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("lbu M", 3'd3, 7'b0000000, 6'b000000, 6'b000000);
      cyc("lbu W", 3'd4, 7'b0010001, 6'b001111, 6'b000001);

      fetch("ori", 32'h3405_0004);
      cyc("ori D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("ori alu_op", 32'(alu_op), 32'd2);
      check("ori zext", 32'(imm_ext), 32'd1);
      check("ori srcB", 32'(alu_srcB), 32'd1);
      cyc("ori E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("ori W", 3'd4, 7'b0010001, 6'b001111, 6'b000000);

      fetch("sll", 32'h0002_1080);
      cyc("sll D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      check("sll alu_op", 32'(alu_op), 32'd4);
      check("sll srcA", 32'(alu_srcA), 32'd1);
      cyc("sll E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("sll W", 3'd4, 7'b0010001, 6'b001111, 6'b000100);

      fetch("mfhi", 32'h0000_2810);
      cyc("mfhi D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      cyc("mfhi E", 3'd2, 7'b0000000, 6'b000000, 6'b000000);
      cyc("mfhi W", 3'd4, 7'b0010001, 6'b001111, 6'b000111);

      fetch("mrst", 32'h0022_0018);
      cyc("mrst D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      cyc("mrst E", 3'd2, 7'b0000100, 6'b000000, 6'b000000);
      cyc("mrst B", 3'd5, 7'b0000010, 6'b000000, 6'b000000);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mrst state", 32'(state), 32'd0);
      check("mrst en", 32'(en_v), 32'd0);
      @(posedge clk);
      #1;
      check("mrst hold state", 32'(state), 32'd0);
      check("mrst hold en", 32'(en_v), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;

      fetch("ill", 32'hFC00_0000);
`ifdef MC_ILLEGAL_TRAP_EN
      cyc("ill D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);
      for (int i = 0; i < 3; i++) begin
         check("ill flag", 32'(illegal), 32'd1);
         cyc("ill H", 3'd6, 7'b0000000, 6'b111111, 6'b000000);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("ill rst flag", 32'(illegal), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
`else
      cyc("ill D", 3'd1, 7'b0000001, 6'b000000, 6'b000000);
`endif
      fetch("post", 32'h0022_1821);
      cyc("post D", 3'd1, 7'b0000000, 6'b000000, 6'b000000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle decoder/controller of the MIPS datapath.
- Decodes the IR word and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, driving datapath enables, selects and ALU/compare codes per state.
- Adds a parametrised multiply/divide wait state.
- Sits between IR/comparator outputs and the PC, GRF, ALU, DM and MDU controls.

Parameters:
- MULT_CYCLES, 5, MDU busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, MDU busy cycles for div/divu (>=1).
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  current IR contents.
- cmp_true  in  1  branch condition from comparator, valid in EXEC.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = j/jal target, 3 = GPR[rs].
- ir_we  out  1  IR write enable.
- reg_we  out  1  GRF write enable.
- rd_sel  out  2  write register: 0 = rt, 1 = rd, 2 = $31.
- d2r  out  2  write data: 0 = ALU, 1 = DM, 2 = PC+4, 3 = HI/LO.
- alu_op  out  5  ALU operation code (add/sub/or/lui/sll encodings as in the single-cycle ALU).
- alu_srcA  out  1  1 = shamt.
- alu_srcB  out  1  1 = extended immediate.
- imm_ext  out  1  1 = zero-extend (ori), 0 = sign-extend.
- mem_we  out  1  DM write enable.
- width_op  out  2  0 = word, 1 = half, 2 = byte.
- sign_or_zero  out  1  1 = zero-extend load (lbu/lhu).
- md_start  out  1  one-cycle MDU start pulse.
- md_op  out  2  0 = mult, 1 = multu, 2 = div, 3 = divu.
- md_busy  out  1  high while in S_MDU.
- instr_done  out  1  pulse on the final cycle of each instruction.
- state  out  3  current state (debug).

Behaviour:
- Supported instructions: addu, subu, sll, jr, mult, multu, div, divu, mfhi, mflo, ori, lui, lw, lh, lhu, lb, lbu, sw, sh, sb, beq, bne, j, jal.
- Any other opcode/funct is illegal.
- State encoding: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_MDU=5, S_HALT=6.
- Reset (reset=0, async): state=S_FETCH, busy counter=0. While reset is low, every enable/pulse output is 0 (pc_we, ir_we, reg_we, mem_we, md_start, instr_done). Selects are 0.
- Reset mid-instruction aborts the instruction immediately. No enable fires in the reset cycle.
- S_FETCH: ir_we=1, pc_we=1, pc_sel=0. Next state S_DECODE.
- S_DECODE:
  - j: pc_we=1, pc_sel=2, instr_done=1. Next state S_FETCH.
  - jal: additionally reg_we=1, rd_sel=2, d2r=2.
  - Illegal: S_FETCH (executed as nop, instr_done=1).
  - All others: S_EXEC.
- S_EXEC:
  - beq/bne: pc_we=cmp_true, pc_sel=1, instr_done=1. Next state S_FETCH.
  - jr: pc_we=1, pc_sel=3, instr_done=1. Next state S_FETCH.
  - mult/multu/div/divu: md_start=1, md_op set, counter loaded with MULT_CYCLES or DIV_CYCLES. Next state S_MDU.
  - Loads/stores: ALU computes the address (alu_op=add, alu_srcB=1). Next state S_MEM.
  - ALU R/I-type and mfhi/mflo: S_WB.
- S_MEM:
  - Store: mem_we=1, width_op set, instr_done=1. Next state S_FETCH.
  - Load: S_WB.
- S_WB: reg_we=1. Selects per instruction: rd_sel=1 for R-type, 0 otherwise; d2r=1 for loads, 3 for mfhi/mflo, 0 otherwise. instr_done=1. Next state S_FETCH.
- S_MDU:
  - md_busy=1; counter decrements each cycle.
  - When counter==1: instr_done=1 and next state is S_FETCH.
  - Total stay = exactly the loaded cycle count.
  - A following mfhi/mflo therefore never observes a busy MDU.
- Decode outputs (alu_op, srcs, imm_ext, width_op, sign_or_zero, md_op) are combinational from instr and hold valid in every state after S_FETCH. Enables are asserted only in the states listed above.
- Cycle counts: j/jal 2; beq/bne/jr 3; ALU/mf 4; store 4; load 5; mult N+3 and div N+3, where N is the MDU parameter.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal instruction in S_DECODE goes to S_HALT.
  - Adds output port illegal (1 bit), asserted and held in S_HALT.
  - No enables fire and no instr_done pulse in S_HALT.
  - S_HALT is left only via reset.
- Undefined: illegal instructions are 2-cycle nops. Port illegal and S_HALT do not exist.

Test Plan:
- Reset release, IR=addu $3,$1,$2 (0x00221821) -> states 0,1,2,4,0. reg_we=1 only in S_WB with rd_sel=1, d2r=0. instr_done at cycle 4.
- lw $5,4($0) (0x8C050004) -> 5 cycles. mem_we never 1. S_WB has d2r=1, rd_sel=0. sw (0xAC050004) -> mem_we=1 in S_MEM, 4 cycles.
- beq with cmp_true=0, then with cmp_true=1 -> pc_we pulses in S_EXEC only when cmp_true=1 (pc_sel=1). Both take 3 cycles.
- mult (0x00220018) with MULT_CYCLES=5 -> md_start is a single pulse in S_EXEC. md_busy high exactly 5 cycles. Total 8 cycles. div with DIV_CYCLES=10 -> 13 cycles.
- jal (0x0C000010) -> 2 cycles. S_DECODE has reg_we=1, rd_sel=2, d2r=2, pc_sel=2.
- Reset pulled low during S_MDU -> state=0 immediately, md_busy=0, no stray enables. Opcode 0x3F: 2-cycle nop without MC_ILLEGAL_TRAP_EN; with it, illegal=1 and held in S_HALT until reset.
